// File: rtl/instruction_emitter.sv
// Instruction emitter: serialises 16-bit {operation, ir_addr} words as HI then LO bytes
// on an 8-bit strobed bus, with a one-entry pending buffer and an optional idle gap.
module instruction_emitter #(
  parameter int GAP = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  operation,
  input  logic [12:0] ir_addr,
  input  logic        hold,
  output logic [7:0]  data,
  output logic        en,
  output logic        busy,
  output logic [7:0]  words_sent,
  output logic [1:0]  state_dbg
);

  // Handshake: a word is accepted on a rising edge where in_valid && in_ready;
  // in_ready depends only on the pending buffer, never on in_valid or hold.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2,
    GAPW = 2'd3
  } state_t;

  localparam logic [3:0] GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  state_t      state, state_nx;
  logic [15:0] active_word, active_nx;
  logic [15:0] pending_word, pending_nx;
  logic        pending_full, pending_full_nx;
  logic [3:0]  gap_cnt, gap_cnt_nx;
  logic [15:0] in_word;
  logic        accept, decide, start;
  logic        en_nx;
  logic [7:0]  data_nx;

  assign in_word   = {operation, ir_addr};
  assign in_ready  = !pending_full;
  assign accept    = in_valid && in_ready;
  assign busy      = (state != IDLE) || pending_full;
  assign state_dbg = state;

  // Start decisions happen only between words, so hold can never split a HI/LO pair.
  always_comb begin
    decide = 1'b0;
    case (state)
      IDLE:    decide = 1'b1;
      LO:      decide = (GAP == 0);
      GAPW:    decide = (gap_cnt == 4'd0);
      default: decide = 1'b0;
    endcase
    start = decide && (pending_full || accept) && !hold;
  end

  always_comb begin
    state_nx        = state;
    active_nx       = active_word;
    pending_nx      = pending_word;
    pending_full_nx = pending_full;
    gap_cnt_nx      = gap_cnt;

    case (state)
      IDLE: state_nx = IDLE;
      HI:   state_nx = LO;
      LO: begin
        if (GAP > 0) begin
          state_nx   = GAPW;
          gap_cnt_nx = GAP_LAST;
        end else begin
          state_nx = IDLE;
        end
      end
      GAPW: begin
        if (gap_cnt == 4'd0) state_nx = IDLE;
        else                 gap_cnt_nx = gap_cnt - 4'd1;
      end
      default: state_nx = IDLE;
    endcase

    // The oldest word becomes active; a word accepted on the same edge refills pending.
    if (start) begin
      state_nx = HI;
      if (pending_full) begin
        active_nx       = pending_word;
        pending_full_nx = accept;
        if (accept) pending_nx = in_word;
      end else begin
        active_nx = in_word;
      end
    end else if (accept) begin
      pending_full_nx = 1'b1;
      pending_nx      = in_word;
    end

    en_nx   = (state_nx == HI) || (state_nx == LO);
    data_nx = 8'h00;
    if (state_nx == HI)      data_nx = active_nx[15:8];
    else if (state_nx == LO) data_nx = active_nx[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      active_word  <= 16'h0000;
      pending_word <= 16'h0000;
      pending_full <= 1'b0;
      gap_cnt      <= 4'd0;
      en           <= 1'b0;
      data         <= 8'h00;
      words_sent   <= 8'd0;
    end else begin
      state        <= state_nx;
      active_word  <= active_nx;
      pending_word <= pending_nx;
      pending_full <= pending_full_nx;
      gap_cnt      <= gap_cnt_nx;
      en           <= en_nx;
      data         <= data_nx;
      if (state == LO) words_sent <= words_sent + 8'd1;
    end
  end

endmodule

// File: tb/tb_instruction_emitter.sv
// Bench for instruction_emitter: directed vector table, GAP=3 sequence, reset abort,
// randomized traffic against a queue-based schedule model, and counter wrap.
module tb_instruction_emitter;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid0, hold0, ready0, en0, busy0;
  logic [2:0]  op0;
  logic [12:0] addr0;
  logic [7:0]  data0, ws0;
  logic [1:0]  st0;
  logic        valid3, hold3, ready3, en3, busy3;
  logic [2:0]  op3;
  logic [12:0] addr3;
  logic [7:0]  data3, ws3;
  logic [1:0]  st3;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  instruction_emitter #(.GAP(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(valid0), .in_ready(ready0),
    .operation(op0), .ir_addr(addr0), .hold(hold0), .data(data0), .en(en0),
    .busy(busy0), .words_sent(ws0), .state_dbg(st0)
  );

  instruction_emitter #(.GAP(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(valid3), .in_ready(ready3),
    .operation(op3), .ir_addr(addr3), .hold(hold3), .data(data3), .en(en3),
    .busy(busy3), .words_sent(ws3), .state_dbg(st3)
  );

  // ---------------- checking ----------------
  task automatic check_bit(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic check_val(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_outs0(input string tag, input logic e, input logic [7:0] d,
                             input logic r, input logic b, input logic [7:0] ws);
    check_bit({tag, " en"}, en0, e);
    check_val({tag, " data"}, {8'h00, data0}, {8'h00, d});
    check_bit({tag, " in_ready"}, ready0, r);
    check_bit({tag, " busy"}, busy0, b);
    check_val({tag, " words_sent"}, {8'h00, ws0}, {8'h00, ws});
  endtask

  // ---------------- reference model (GAP=0 instance) ----------------
  // Each future bus cycle is a slot; a start decision happens only when nothing is
  // scheduled for the next cycle. Words waiting to start live in m_q.
  localparam logic [1:0] K_IDLE = 2'd0, K_HI = 2'd1, K_LO = 2'd2, K_GAP = 2'd3;
  typedef struct packed { logic [1:0] kind; logic [7:0] b; } slot_t;
  slot_t       m_sched[$];
  logic [15:0] m_q[$];
  slot_t       m_cur;
  logic [7:0]  m_ws;
  int          m_gap = 0;

  task automatic model_edge(input logic r, input logic v, input logic h, input logic [15:0] w);
    logic [15:0] nw;
    if (r) begin
      m_sched.delete();
      m_q.delete();
      m_cur = '{K_IDLE, 8'h00};
      m_ws  = 8'd0;
      return;
    end
    if (v && m_q.size() == 0) m_q.push_back(w);
    if (m_cur.kind == K_LO) m_ws = m_ws + 8'd1;
    if (m_sched.size() > 0) begin
      m_cur = m_sched.pop_front();
    end else if (m_q.size() > 0 && !h) begin
      nw    = m_q.pop_front();
      m_cur = '{K_HI, nw[15:8]};
      m_sched.push_back('{K_LO, nw[7:0]});
      for (int i = 0; i < m_gap; i++) m_sched.push_back('{K_GAP, 8'h00});
    end else begin
      m_cur = '{K_IDLE, 8'h00};
    end
  endtask

  task automatic check_model(input string tag);
    logic e;
    e = (m_cur.kind == K_HI) || (m_cur.kind == K_LO);
    check_outs0(tag, e, e ? m_cur.b : 8'h00, m_q.size() == 0,
                (m_cur.kind != K_IDLE) || (m_q.size() > 0), m_ws);
  endtask

  // ---------------- drivers ----------------
  task automatic drive0(input logic v, input logic [15:0] w, input logic h);
    valid0 = v;
    op0    = w[15:13];
    addr0  = w[12:0];
    hold0  = h;
  endtask

  task automatic drive3(input logic v, input logic [15:0] w);
    valid3 = v;
    op3    = w[15:13];
    addr3  = w[12:0];
    hold3  = 1'b0;
  endtask

  task automatic step();
    model_edge(rst, valid0, hold0, {op0, addr0});
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        v;
    logic [15:0] w;
    logic        h;
    logic        e;
    logic [7:0]  d;
    logic        r;
    logic        b;
    logic [7:0]  ws;
  } vec_t;

  vec_t tbl[18];

  logic [7:0] g3_d[11] = '{8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h56, 8'h78, 8'h00, 8'h00, 8'h00, 8'h00};
  logic       g3_e[11] = '{1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0};
  logic       g3_r[11] = '{1, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
  logic       g3_b[11] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int    accepted;
    int    drain;
    logic  saw_255;
    m_gap = 0;
    m_cur = '{K_IDLE, 8'h00};
    m_ws  = 8'd0;
    //          v   word       h  en  data   rdy busy ws
    tbl[0]  = '{1, 16'hAA5C, 0, 1, 8'hAA, 1, 1, 8'd0};  // single word HI
    tbl[1]  = '{0, 16'h0000, 0, 1, 8'h5C, 1, 1, 8'd0};
    tbl[2]  = '{0, 16'h0000, 0, 0, 8'h00, 1, 0, 8'd1};
    tbl[3]  = '{1, 16'h1234, 0, 1, 8'h12, 1, 1, 8'd1};  // back-to-back pair
    tbl[4]  = '{1, 16'hFEDC, 0, 1, 8'h34, 0, 1, 8'd1};
    tbl[5]  = '{0, 16'h0000, 0, 1, 8'hFE, 1, 1, 8'd2};
    tbl[6]  = '{0, 16'h0000, 0, 1, 8'hDC, 1, 1, 8'd2};
    tbl[7]  = '{0, 16'h0000, 0, 0, 8'h00, 1, 0, 8'd3};
    tbl[8]  = '{1, 16'h1111, 1, 0, 8'h00, 0, 1, 8'd3};  // held while queued
    tbl[9]  = '{0, 16'h0000, 1, 0, 8'h00, 0, 1, 8'd3};
    tbl[10] = '{0, 16'h0000, 0, 1, 8'h11, 1, 1, 8'd3};
    tbl[11] = '{0, 16'h0000, 1, 1, 8'h11, 1, 1, 8'd3};  // hold during HI
    tbl[12] = '{0, 16'h0000, 1, 0, 8'h00, 1, 0, 8'd4};
    tbl[13] = '{1, 16'h2233, 0, 1, 8'h22, 1, 1, 8'd4};
    tbl[14] = '{0, 16'h0000, 0, 1, 8'h33, 1, 1, 8'd4};
    tbl[15] = '{1, 16'h4455, 0, 1, 8'h44, 1, 1, 8'd5};  // accept at LO exit
    tbl[16] = '{0, 16'h0000, 0, 1, 8'h55, 1, 1, 8'd5};
    tbl[17] = '{0, 16'h0000, 0, 0, 8'h00, 1, 0, 8'd6};

    // clock/reset
    rst = 1'b1;
    drive0(0, 16'h0000, 0);
    drive3(0, 16'h0000);
    @(negedge clk);
    step();
    step();
    rst = 1'b0;
    check_outs0("reset", 1'b0, 8'h00, 1'b1, 1'b0, 8'd0);
    check_bit("reset dut3 en", en3, 1'b0);
    check_bit("reset dut3 in_ready", ready3, 1'b1);

    for (int i = 0; i < 18; i++) begin
      drive0(tbl[i].v, tbl[i].w, tbl[i].h);
      step();
      check_outs0($sformatf("vec%0d", i), tbl[i].e, tbl[i].d, tbl[i].r, tbl[i].b, tbl[i].ws);
    end
    drive0(0, 16'h0000, 0);

    // GAP=3: two queued words
    drive3(1, 16'h1234);
    step();
    check_bit("gap3 s0 en", en3, g3_e[0]);
    check_val("gap3 s0 data", {8'h00, data3}, {8'h00, g3_d[0]});
    drive3(1, 16'h5678);
    for (int i = 1; i < 11; i++) begin
      step();
      drive3(0, 16'h0000);
      check_bit($sformatf("gap3 s%0d en", i), en3, g3_e[i]);
      check_val($sformatf("gap3 s%0d data", i), {8'h00, data3}, {8'h00, g3_d[i]});
      check_bit($sformatf("gap3 s%0d in_ready", i), ready3, g3_r[i]);
      check_bit($sformatf("gap3 s%0d busy", i), busy3, g3_b[i]);
    end
    check_val("gap3 words_sent", {8'h00, ws3}, 16'd2);

    // reset during HI of BEEF
    drive0(1, 16'hBEEF, 0);
    step();
    check_val("abort hi data", {8'h00, data0}, 16'h00BE);
    drive0(0, 16'h0000, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_outs0("abort rst", 1'b0, 8'h00, 1'b1, 1'b0, 8'd0);
    step();
    check_outs0("abort after", 1'b0, 8'h00, 1'b1, 1'b0, 8'd0);

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      drive0($urandom_range(0, 9) < 6, 16'($urandom), $urandom_range(0, 3) == 0);
      step();
      check_model($sformatf("rand%0d", i));
    end
    rst = 1'b0;

    // words_sent wrap after 256 words
    rst = 1'b1;
    drive0(0, 16'h0000, 0);
    step();
    rst = 1'b0;
    accepted = 0;
    saw_255  = 1'b0;
    for (int i = 0; i < 2000 && accepted < 256; i++) begin
      drive0(1, 16'($urandom), 0);
      if (ready0) accepted++;
      step();
      if (ws0 == 8'd255) saw_255 = 1'b1;
      check_model($sformatf("wrap%0d", i));
    end
    drive0(0, 16'h0000, 0);
    drain = 0;
    while (busy0 && drain < 10) begin
      step();
      if (ws0 == 8'd255) saw_255 = 1'b1;
      drain++;
    end
    check_val("wrap accepted", 16'(accepted), 16'd256);
    check_bit("wrap drained", busy0, 1'b0);
    check_bit("wrap saw 255", saw_255, 1'b1);
    check_val("wrap words_sent", {8'h00, ws0}, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/instruction_emitter.md
INSTRUCTION_EMITTER -- requirements
Module: instruction_emitter

Interface
REQ-001 SHALL have parameter GAP, default 0, the minimum number of idle cycles (en=0) inserted between consecutive emitted words, range 0..15.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: a 16-bit instruction word is offered.
REQ-005 SHALL have port in_ready, output, 1 bit: the emitter can accept a word this cycle.
REQ-006 SHALL have port operation, input, 3 bits: the instruction opcode, placed in word bits [15:13].
REQ-007 SHALL have port ir_addr, input, 13 bits: the instruction address, placed in word bits [12:0].
REQ-008 SHALL have port hold, input, 1 bit: the consumer asks the emitter not to start a new word.
REQ-009 SHALL have port data, output, 8 bits: byte driven onto the 8-bit data bus.
REQ-010 SHALL have port en, output, 1 bit: byte strobe; data is valid to the instruction register when en is high.
REQ-011 SHALL have port busy, output, 1 bit: high while a word is being emitted or is buffered.
REQ-012 SHALL have port words_sent, output, 8 bits: count of completed words, wrapping.

Function
REQ-013 SHALL form word = {operation, ir_addr} at acceptance; accept occurs on a rising edge with in_valid && in_ready.
REQ-014 SHALL hold at most two words: one active (being emitted) plus one pending buffer entry; in_ready = !pending_full.
REQ-015 SHALL use a state machine with states IDLE, HI, LO, GAPW.
REQ-016 IDLE: if a word is available (pending, or accepted this edge) and hold=0, SHALL go to HI; otherwise SHALL stay in IDLE.
REQ-017 HI: SHALL drive en=1 and data=word[15:8] for exactly one cycle, then SHALL go to LO unconditionally.
REQ-018 LO: SHALL drive en=1 and data=word[7:0] for exactly one cycle, SHALL increment words_sent, then SHALL go to GAPW if GAP>0, otherwise apply the IDLE decision directly (back-to-back HI allowed).
REQ-019 GAPW: SHALL drive en=0 for exactly GAP cycles, then SHALL go to IDLE.
REQ-020 The HI and LO bytes of one word SHALL always be on consecutive cycles; hold SHALL never split a pair (the consumer's byte phase resets whenever en drops).
REQ-021 hold SHALL be sampled only at the start decision (IDLE, or LO exit with GAP=0); hold asserted during HI/LO SHALL have no effect on the current word.
REQ-022 en and data SHALL be registered outputs; when en=0, data SHALL be 8'h00.
REQ-023 Latency: a word accepted at edge N into an empty emitter with hold=0 SHALL produce HI at cycle N+1 and LO at cycle N+2.
REQ-024 With pending full and active emission, SHALL keep in_ready=0 until the pending word moves to active (at the LO exit edge).
REQ-025 Simultaneous accept and LO exit with no pending word: the new word SHALL go directly to active and HI SHALL follow immediately (GAP=0, hold=0).
REQ-026 busy SHALL be high when the state is not IDLE or the pending buffer is full.
REQ-027 words_sent SHALL wrap from 255 to 0.

Reset
REQ-028 When rst=1 at an edge, SHALL set state=IDLE, clear the pending buffer and active word to 0, and set en=0, data=8'h00, words_sent=0, busy=0, in_ready=1.
REQ-029 Reset mid-word (during HI or LO) SHALL abort emission; no LO byte SHALL follow, and the aborted word SHALL not be counted.
REQ-030 in_ready SHALL be 1 in the first cycle after rst is released.

Verification
REQ-031 Single word: operation=3'b101, ir_addr=13'h0A5C, GAP=0 -> en=1 with data=8'hAA at N+1, then data=8'h5C at N+2; words_sent=1.
REQ-032 Back-to-back: two words 16'h1234 and 16'hFEDC, GAP=0, hold=0 -> data sequence 12,34,FE,DC on four consecutive en=1 cycles; in_ready=0 only while pending is full.
REQ-033 GAP=3: two queued words -> exactly 3 en=0 cycles between the first LO and the second HI.
REQ-034 hold=1 while one word is queued -> en stays 0 and busy=1; hold released -> HI on the next cycle; hold asserted during HI -> LO still follows.
REQ-035 rst asserted during HI of 16'hBEEF -> next cycle en=0, words_sent=0, in_ready=1, no 8'hEF emitted.
REQ-036 256 words emitted -> words_sent wraps to 0.
